// File: rtl/pipeline_hazard_controller.sv
// Pipeline stall/flush controller: resolves load-use stalls, branch flushes and DRAM
// freezes, with a DRAM timeout that parks the pipeline in HALT until reset.
module pipeline_hazard_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DataHazard,
    input  logic        EXBranchTaken,
    input  logic        MEMDramReq,
    input  logic        DramReady,
    output logic        PcStall,
    output logic        IFIDStall,
    output logic        IDEXStall,
    output logic        EXMEMStall,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        MEMWBFlush,
    output logic        MemTimeout,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    localparam logic [1:0]  RUN       = 2'd0;
    localparam logic [1:0]  MEM_WAIT  = 2'd1;
    localparam logic [1:0]  HALT      = 2'd2;
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [7:0]  wait_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        freeze;
    logic        branch_flush;
    logic        load_use;
    logic        enter_wait;
    logic        wait_expire;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        freeze       = 1'b0;
        branch_flush = 1'b0;
        load_use     = 1'b0;
        enter_wait   = 1'b0;
        wait_expire  = 1'b0;
        next_state   = state;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (MEMDramReq && !DramReady) begin
                        freeze     = 1'b1;
                        enter_wait = 1'b1;
                        next_state = MEM_WAIT;
                    end else begin
                        branch_flush = EXBranchTaken;
                        load_use     = !EXBranchTaken && DataHazard;
                    end
                end
                MEM_WAIT: begin
                    if (!DramReady) begin
                        freeze = 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            wait_expire = 1'b1;
                            next_state  = HALT;
                        end
                    end else begin
                        // Data has arrived, so the releasing cycle resolves hazards as RUN would.
                        branch_flush = EXBranchTaken;
                        load_use     = !EXBranchTaken && DataHazard;
                        next_state   = RUN;
                    end
                end
                HALT:    freeze     = 1'b1;
                default: next_state = RUN;
            endcase
        end
    end

    assign PcStall    = freeze || load_use;
    assign IFIDStall  = freeze || load_use;
    assign IDEXStall  = freeze;
    assign EXMEMStall = freeze;
    assign MEMWBFlush = freeze;
    assign IFIDFlush  = branch_flush;
    assign IDEXFlush  = branch_flush || load_use;
    assign StallCount = stall_cnt;
    assign FlushCount = flush_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            wait_cnt   <= 8'd0;
            MemTimeout <= 1'b0;
            stall_cnt  <= 32'd0;
            flush_cnt  <= 32'd0;
        end else begin
            state <= next_state;
            if (enter_wait)
                wait_cnt <= 8'd0;
            else if (state == MEM_WAIT && !DramReady)
                wait_cnt <= wait_cnt + 8'd1;
            if (wait_expire)
                MemTimeout <= 1'b1;
            // HALT holds the stall lines but is an error condition, not pipeline work.
            if (PcStall && state != HALT && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 32'd1;
            if (branch_flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: RUN-state vector table plus
// hand-written DRAM wait, timeout/HALT, branch-during-wait and saturation sequences.
module tb_pipeline_hazard_controller;

    localparam logic [6:0] O_NONE = 7'b0000_000;
    localparam logic [6:0] O_FRZ  = 7'b1111_001;
    localparam logic [6:0] O_BR   = 7'b0000_110;
    localparam logic [6:0] O_HZ   = 7'b1100_010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        DataHazard = 1'b1;
    logic        EXBranchTaken = 1'b1;
    logic        MEMDramReq = 1'b1;
    logic        DramReady = 1'b0;
    logic        PcStall, IFIDStall, IDEXStall, EXMEMStall;
    logic        IFIDFlush, IDEXFlush, MEMWBFlush, MemTimeout;
    logic [31:0] StallCount, FlushCount;

    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] exp_stall = 32'd0;
    logic [31:0] exp_flush = 32'd0;
    logic        exp_to = 1'b0;
    logic [31:0] mark;

    typedef struct {
        logic [3:0] in;    // {DataHazard, EXBranchTaken, MEMDramReq, DramReady}
        logic [6:0] exp;   // {PcStall, IFIDStall, IDEXStall, EXMEMStall, IFIDFlush, IDEXFlush, MEMWBFlush}
    } vec_t;

    vec_t vecs[10];

    pipeline_hazard_controller #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .DataHazard    (DataHazard),
        .EXBranchTaken (EXBranchTaken),
        .MEMDramReq    (MEMDramReq),
        .DramReady     (DramReady),
        .PcStall       (PcStall),
        .IFIDStall     (IFIDStall),
        .IDEXStall     (IDEXStall),
        .EXMEMStall    (EXMEMStall),
        .IFIDFlush     (IFIDFlush),
        .IDEXFlush     (IDEXFlush),
        .MEMWBFlush    (MEMWBFlush),
        .MemTimeout    (MemTimeout),
        .StallCount    (StallCount),
        .FlushCount    (FlushCount)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [6:0] outs();
        return {PcStall, IFIDStall, IDEXStall, EXMEMStall, IFIDFlush, IDEXFlush, MEMWBFlush};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] in);
        {DataHazard, EXBranchTaken, MEMDramReq, DramReady} = in;
    endtask

    // One clock: drive at negedge, check outputs before the edge, counters after it.
    task automatic cycle(input logic [3:0] in, input logic [6:0] exp, input bit in_halt, input string name);
        @(negedge clk);
        drive(in);
        #1;
        check({name, " outs"}, 32'(outs()), 32'(exp));
        if (exp[6] && !in_halt && exp_stall != 32'hFFFF_FFFF)
            exp_stall = exp_stall + 32'd1;
        if (exp == O_BR)
            exp_flush = exp_flush + 32'd1;
        @(posedge clk);
        #1;
        check({name, " StallCount"}, StallCount, exp_stall);
        check({name, " FlushCount"}, FlushCount, exp_flush);
        check({name, " MemTimeout"}, 32'(MemTimeout), 32'(exp_to));
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'b1110);
        #1;
        check({name, " outs in reset"}, 32'(outs()), 32'(O_NONE));
        @(posedge clk);
        #1;
        check({name, " StallCount"}, StallCount, 32'd0);
        check({name, " FlushCount"}, FlushCount, 32'd0);
        check({name, " MemTimeout"}, 32'(MemTimeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000);
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        exp_to    = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'b0000, O_NONE};
        vecs[1] = '{4'b1000, O_HZ};
        vecs[2] = '{4'b0100, O_BR};
        vecs[3] = '{4'b1100, O_BR};
        vecs[4] = '{4'b0011, O_NONE};
        vecs[5] = '{4'b1011, O_HZ};
        vecs[6] = '{4'b0111, O_BR};
        vecs[7] = '{4'b0010, O_FRZ};
        vecs[8] = '{4'b1110, O_FRZ};
        vecs[9] = '{4'b1010, O_FRZ};

        // Reset held over two edges with every input active.
        @(posedge clk);
        do_reset("initial reset");

        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].in, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
            // A freeze parks the FSM in MEM_WAIT; a ready cycle releases it with no hazard.
            if (vecs[i].exp == O_FRZ)
                cycle(4'b0001, O_NONE, 1'b0, $sformatf("vec%0d release", i));
        end

        // Load-use: StallCount 0 -> 1.
        do_reset("reset A");
        cycle(4'b1000, O_HZ, 1'b0, "load-use");
        check("load-use StallCount is 1", StallCount, 32'd1);

        // Branch together with hazard: flush wins, no stall counted.
        mark = StallCount;
        cycle(4'b1100, O_BR, 1'b0, "branch+hazard");
        check("branch+hazard StallCount unchanged", StallCount, mark);

        // DRAM wait: 3 frozen cycles, release on 4th, RUN on 5th.
        mark = StallCount;
        cycle(4'b0010, O_FRZ, 1'b0, "dram wait 1");
        cycle(4'b0010, O_FRZ, 1'b0, "dram wait 2");
        cycle(4'b1110, O_FRZ, 1'b0, "dram wait 3");
        cycle(4'b0011, O_NONE, 1'b0, "dram release");
        check("dram wait StallCount +3", StallCount, mark + 32'd3);
        cycle(4'b1000, O_HZ, 1'b0, "dram back in RUN");

        // Branch held through MEM_WAIT: exactly one flush, on the ready cycle.
        mark = FlushCount;
        cycle(4'b0110, O_FRZ, 1'b0, "br-wait enter");
        cycle(4'b0110, O_FRZ, 1'b0, "br-wait 1");
        cycle(4'b0110, O_FRZ, 1'b0, "br-wait 2");
        cycle(4'b0111, O_BR, 1'b0, "br-wait release");
        cycle(4'b0000, O_NONE, 1'b0, "br-wait after");
        check("br-wait FlushCount +1", FlushCount, mark + 32'd1);

        // Timeout with TIMEOUT=4: MemTimeout after the 4th wait cycle, then HALT.
        do_reset("reset B");
        cycle(4'b0010, O_FRZ, 1'b0, "to enter");
        for (int i = 0; i < 4; i++) begin
            if (i == 3)
                exp_to = 1'b1;
            cycle(4'b0010 | {2'(i), 2'b00}, O_FRZ, 1'b0, $sformatf("to wait%0d", i + 1));
        end
        for (int i = 0; i < 20; i++)
            cycle(4'(i), O_FRZ, 1'b1, $sformatf("halt%0d", i));
        check("halt StallCount excludes HALT", StallCount, 32'd5);

        // Reset abandons HALT; afterwards the FSM is back in RUN with nothing pending.
        do_reset("reset from HALT");
        cycle(4'b0000, O_NONE, 1'b0, "post-halt idle");
        cycle(4'b0100, O_BR, 1'b0, "post-halt branch");

        // Reset mid-MEM_WAIT, then a hazard must resolve as in RUN.
        cycle(4'b0010, O_FRZ, 1'b0, "mid-wait enter");
        cycle(4'b0010, O_FRZ, 1'b0, "mid-wait 1");
        do_reset("reset from MEM_WAIT");
        cycle(4'b1010, O_FRZ, 1'b0, "post-wait reenter");
        cycle(4'b0001, O_NONE, 1'b0, "post-wait release");
        cycle(4'b1000, O_HZ, 1'b0, "post-wait hazard");

        // Saturation: preset StallCount near the top, then 3 stall cycles.
        cycle(4'b0000, O_NONE, 1'b0, "pre-sat idle");
        @(negedge clk);
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        exp_stall = 32'hFFFF_FFFE;
        check("sat preset", StallCount, 32'hFFFF_FFFE);
        cycle(4'b1000, O_HZ, 1'b0, "sat1");
        cycle(4'b1000, O_HZ, 1'b0, "sat2");
        cycle(4'b1000, O_HZ, 1'b0, "sat3");
        check("sat final StallCount", StallCount, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
